// File: rtl/perspective_correct_if.sv
// Fragment stream and reciprocal side-channel of the perspective-correction stage.
// The slave modport is the stage; master is the surrounding fabric (rasterizer, reciprocal, sampler).
interface perspective_correct_if #(
   parameter int unsigned XY_WIDTH = 16
);
   localparam int unsigned DW = 32;

   logic                in_valid_i;
   logic                in_ready_o;
   logic [XY_WIDTH-1:0] in_x_i;
   logic [XY_WIDTH-1:0] in_y_i;
   logic [DW-1:0]       in_z_i;
   logic [DW-1:0]       in_w_inv_i;
   logic [DW-1:0]       in_u_w_i;
   logic [DW-1:0]       in_v_w_i;
   logic [DW-1:0]       recip_x_o;
   logic [DW-1:0]       recip_z_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [XY_WIDTH-1:0] out_x_o;
   logic [XY_WIDTH-1:0] out_y_o;
   logic [DW-1:0]       out_z_o;
   logic [DW-1:0]       out_u_o;
   logic [DW-1:0]       out_v_o;

   modport slave (
      input  in_valid_i, in_x_i, in_y_i, in_z_i, in_w_inv_i, in_u_w_i, in_v_w_i,
      input  recip_z_i, out_ready_i,
      output in_ready_o, recip_x_o,
      output out_valid_o, out_x_o, out_y_o, out_z_o, out_u_o, out_v_o
   );

   modport master (
      output in_valid_i, in_x_i, in_y_i, in_z_i, in_w_inv_i, in_u_w_i, in_v_w_i,
      output recip_z_i, out_ready_i,
      input  in_ready_o, recip_x_o,
      input  out_valid_o, out_x_o, out_y_o, out_z_o, out_u_o, out_v_o
   );
endinterface

// File: rtl/perspective_correct.sv
// Three-stage perspective correction: S0 feeds 1/w to the external reciprocal,
// S1 captures w, S2 multiplies w into u/w and v/w. One global stall for all stages.
module perspective_correct #(
   parameter int unsigned FRAC_BITS = 16,
   parameter int unsigned XY_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n_i,
   perspective_correct_if.slave  bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 2 * DW;

   typedef struct packed {
      logic [XY_WIDTH-1:0] x;
      logic [XY_WIDTH-1:0] y;
      logic [DW-1:0]       z;
   } pos_t;

   logic          advance;
   logic          s0_valid, s1_valid, s2_valid;
   pos_t          s0_pos, s1_pos, s2_pos;
   logic [DW-1:0] s0_w_inv, s0_u_w, s0_v_w;
   logic [DW-1:0] s1_w, s1_u_w, s1_v_w;
   logic [DW-1:0] s2_u, s2_v;
   logic [DW-1:0] u_c, v_c;
   pos_t          in_pos;

   // Signed 16.16 multiply, wrapping to 32 bits after the fractional realign.
   function automatic logic [DW-1:0] fx_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [PW-1:0] prod;
      prod = PW'($signed(a)) * PW'($signed(b));
      return DW'(prod >>> FRAC_BITS);
   endfunction

   assign advance        = !s2_valid || bus.out_ready_i;
   assign bus.in_ready_o = advance;

   assign in_pos = '{x: bus.in_x_i, y: bus.in_y_i, z: bus.in_z_i};
   assign u_c    = fx_mul(s1_u_w, s1_w);
   assign v_c    = fx_mul(s1_v_w, s1_w);

   // Pipeline registers; payload may go stale behind a bubble, valids are exact.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s0_valid <= 1'b0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s0_pos   <= '0;
         s1_pos   <= '0;
         s2_pos   <= '0;
         s0_w_inv <= '0;
         s0_u_w   <= '0;
         s0_v_w   <= '0;
         s1_w     <= '0;
         s1_u_w   <= '0;
         s1_v_w   <= '0;
         s2_u     <= '0;
         s2_v     <= '0;
      end else if (advance) begin
         s0_valid <= bus.in_valid_i;
         s0_pos   <= in_pos;
         // Zeroed when invalid so the reciprocal operand is 0 for empty S0
         s0_w_inv <= bus.in_valid_i ? bus.in_w_inv_i : '0;
         s0_u_w   <= bus.in_u_w_i;
         s0_v_w   <= bus.in_v_w_i;

         s1_valid <= s0_valid;
         s1_pos   <= s0_pos;
         s1_w     <= bus.recip_z_i;
         s1_u_w   <= s0_u_w;
         s1_v_w   <= s0_v_w;

         s2_valid <= s1_valid;
         s2_pos   <= s1_pos;
         s2_u     <= u_c;
         s2_v     <= v_c;
      end
   end

   assign bus.recip_x_o   = s0_w_inv;
   assign bus.out_valid_o = s2_valid;
   assign bus.out_x_o     = s2_pos.x;
   assign bus.out_y_o     = s2_pos.y;
   assign bus.out_z_o     = s2_pos.z;
   assign bus.out_u_o     = s2_u;
   assign bus.out_v_o     = s2_v;
endmodule

// File: doc/perspective_correct.md
Name: perspective_correct

Overview:
- Pipelined fragment stage directly downstream of the rasterizer interpolators.
- Drives the 1/w interpolant into an external combinational reciprocal instance. The instance computes NUMERATOR/x in 16.16.
- Captures the recovered w and multiplies it into the interpolated u/w and v/w to produce perspective-correct texture coordinates.
- Forwards fragments to the texture sampler over a valid/ready handshake, with full backpressure.

Parameters:
- FRAC_BITS, 16, fractional bits of every fixed-point operand (16.16 signed).
- XY_WIDTH, 16, width of the screen-coordinate fields carried through unchanged.

Ports:
- clk  input  1  system clock
- reset_n_i  input  1  asynchronous active-low reset
- in_valid_i  input  1  upstream fragment valid
- in_ready_o  output  1  stage accepts a fragment this cycle
- in_x_i  input  XY_WIDTH  fragment x
- in_y_i  input  XY_WIDTH  fragment y
- in_z_i  input  32  depth, passthrough
- in_w_inv_i  input  32  interpolated 1/w, 16.16
- in_u_w_i  input  32  interpolated u/w, 16.16 signed
- in_v_w_i  input  32  interpolated v/w, 16.16 signed
- recip_x_o  output  32  operand to the external reciprocal
- recip_z_i  input  32  reciprocal result, combinational from recip_x_o, 16.16
- out_valid_o  output  1  corrected fragment valid
- out_ready_i  input  1  downstream accepts
- out_x_o  output  XY_WIDTH  fragment x
- out_y_o  output  XY_WIDTH  fragment y
- out_z_o  output  32  depth
- out_u_o  output  32  perspective-correct u, 16.16 signed
- out_v_o  output  32  perspective-correct v, 16.16 signed

Behaviour:
- Pipeline structure: three register stages, S0 → S1 → S2. Each stage holds a valid bit plus its payload.
- Global advance: advance = !S2.valid || out_ready_i. in_ready_o = advance (combinational).
  - When advance=1, every stage loads from its predecessor.
  - S0 loads from the inputs; its valid becomes in_valid_i.
  - When advance=0, all stages hold.
- S0:
  - Registers x, y, z, w_inv, u_w and v_w.
  - recip_x_o = S0.w_inv, driven from the register, never from the inputs.
  - recip_x_o is 0 when S0 is invalid.
- S1:
  - Captures w = recip_z_i together with S0's payload.
  - The reciprocal path is purely combinational, so it must settle within one cycle from the S0 register.
- S2 arithmetic:
  - u = (signed 64-bit product of S1.u_w and S1.w) >>> FRAC_BITS, truncated to the low 32 bits (wrap, no saturation). v is computed the same way.
  - x, y and z pass through unchanged.
- Outputs: out_* = S2 registers; out_valid_o = S2.valid.
- Latency and throughput:
  - Exactly 3 cycles from acceptance to out_valid_o, with no stalls.
  - Throughput is 1 fragment per cycle.
- Payload stability: while out_valid_o=1 and out_ready_i=0, all out_* remain stable. in_ready_o=0 during this time, and no fragment is lost or duplicated.
- w edge cases:
  - w_inv = 0: the reciprocal returns NUMERATOR<<16, which is used as-is.
  - w_inv beyond the reciprocal's interpolation region: the reciprocal returns 0, so u = v = 0 and the fragment is still emitted.
- Bubbles: a bubble (in_valid_i=0 while advance=1) propagates as an invalid stage. Payload registers may hold stale data, but valid bits must be exact.
- Simultaneous in_valid_i=1 and out_ready_i=0 with S2 full: the input is not accepted, and upstream must hold.
- Reset (asynchronous, mid-operation included):
  - All valid bits clear immediately; out_valid_o=0.
  - All payload outputs are 0 and recip_x_o=0.
  - in_ready_o=1 after reset because S2 is empty.
  - In-flight fragments are discarded.
  - First acceptance is on the first rising edge after reset_n_i deasserts.

Test Plan:
- Single fragment, bench drives recip_z_i with a NUMERATOR=256 reciprocal model. Inputs: w_inv=0x00010000, u_w=0x00000100, v_w=0x00000080, x=10, y=20, z=0x1234, out_ready_i=1. Required: out_valid_o pulses 3 cycles after acceptance with u=0x00010000, v=0x00008000, x=10, y=20, z=0x1234.
- Signed operand: w_inv=0x00020000 (w=0x00800000), u_w=0xFFFFFE00. Required: u=0xFFFF0000 (-1.0).
- Back-to-back stream of 8 fragments, out_ready_i=1. Required: 8 consecutive out_valid_o cycles in input order, with no gaps after the 3-cycle fill.
- Backpressure: hold out_ready_i=0 for 5 cycles with the pipe full. Required: in_ready_o=0, outputs frozen, then all fragments drain in order with none dropped or duplicated.
- Far fragment with w_inv=0x80000000 (reciprocal returns 0). Required: u=v=0 and the fragment is still emitted.
- Assert reset_n_i low mid-stream with 3 fragments in flight. Required: out_valid_o=0 and recip_x_o=0 asynchronously, no stale fragment emitted after release, and a new fragment appears exactly 3 cycles after acceptance.
